// File: rtl/mem_bus_ctrl_8085_pkg.sv
// Shared definitions for the 8085 memory bus controller: bus widths,
// FSM state encoding and the default protected-region base.
package mem8085_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int ST_W   = 3;

  localparam logic [ADDR_W-1:0] PROT_BASE_DEF = 8'h80;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_SETUP  = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT   = 3'd2;
  localparam logic [ST_W-1:0] ST_ACCESS = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE   = 3'd4;
endpackage

// File: rtl/mem_bus_ctrl_8085_if.sv
// Request/response and memory-side signals of the bus controller.
// master = control unit plus memory model, slave = the controller.
interface mem_bus_ctrl_8085_if;
  import mem8085_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic              busy;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata_out;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dataw;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output req, we, addr_in, wdata_in, mem_data,
    input  busy, ack, err, rdata_out, mem_addr, mem_dataw, mem_read, mem_write
  );

  modport slave (
    input  req, we, addr_in, wdata_in, mem_data,
    output busy, ack, err, rdata_out, mem_addr, mem_dataw, mem_read, mem_write
  );
endinterface

// File: rtl/mem_bus_ctrl_8085.sv
// Sequences one load/store at a time onto a single-port memory with
// programmable wait states; writes to the upper constant table are refused.
module mem_bus_ctrl_8085
  import mem8085_pkg::*;
#(
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] PROT_BASE   = PROT_BASE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_ctrl_8085_if.slave  bus
);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [ST_W-1:0] state;
  logic            op;
  logic [3:0]      cnt;

  // Every output is a register; strobes are set on the edge entering ACCESS
  // so they are high for exactly that one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      op            <= 1'b0;
      cnt           <= 4'd0;
      bus.busy      <= 1'b0;
      bus.ack       <= 1'b0;
      bus.err       <= 1'b0;
      bus.rdata_out <= '0;
      bus.mem_addr  <= '0;
      bus.mem_dataw <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            bus.mem_addr  <= bus.addr_in;
            bus.mem_dataw <= bus.wdata_in;
            op            <= bus.we;
            bus.err       <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (op && (bus.mem_addr >= PROT_BASE)) begin
            bus.err <= 1'b1;
            bus.ack <= 1'b1;
            state   <= ST_DONE;
          end else if (WAIT_CYCLES == 0) begin
            bus.mem_read  <= ~op;
            bus.mem_write <= op;
            state         <= ST_ACCESS;
          end else begin
            cnt   <= CNT_LOAD;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            bus.mem_read  <= ~op;
            bus.mem_write <= op;
            state         <= ST_ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ACCESS: begin
          if (!op) bus.rdata_out <= bus.mem_data;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          bus.ack       <= 1'b1;
          state         <= ST_DONE;
        end
        ST_DONE: begin
          bus.ack  <= 1'b0;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          bus.ack       <= 1'b0;
          bus.busy      <= 1'b0;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
